pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning max MEM_WAIT cycles before fault (legal 2..255).
REQ-002 SHALL have port clock  input  1  single clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port ex_mem_read  input  1  ID/EX buffer holds a load.
REQ-005 SHALL have port ex_dest  input  5  destination register in ID/EX.
REQ-006 SHALL have ports id_rs, id_rt  input  5 each  source registers in IF/ID.
REQ-007 SHALL have port id_uses_rt  input  1  IF/ID instruction reads rt.
REQ-008 SHALL have port mem_jmp  input  1  taken jump/branch in EX/MEM buffer.
REQ-009 SHALL have port mem_access  input  1  EX/MEM buffer holds a load/store.
REQ-010 SHALL have port mem_ready  input  1  data-memory completion.
REQ-011 SHALL have ports load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  output  1 each  pipeline register load enables.
REQ-012 SHALL have ports flush_if_id, flush_id_ex, flush_ex_mem  output  1 each  bubble insertion.
REQ-013 SHALL have port state  output  2  RUN=0, LU_STALL=1, MEM_WAIT=2, FAULT=3.
REQ-014 SHALL have port mem_timeout  output  1  sticky fault flag.

Function
REQ-015 Outputs SHALL decode combinationally from current state and inputs; state and counters update on clock rising edge.
REQ-016 Load-use hazard SHALL be: ex_mem_read & ex_dest!=0 & (ex_dest==id_rs | (id_uses_rt & ex_dest==id_rt)).
REQ-017 RUN decision priority SHALL be: memory wait > jump > load-use > normal.
REQ-018 RUN, mem_access=1, mem_ready=0: all loads 0, all flushes 0, next MEM_WAIT, wait_cnt=1.
REQ-019 RUN, mem_jmp=1 (memory not blocking): all loads 1, flush_if_id=flush_id_ex=flush_ex_mem=1, next RUN; a simultaneous load-use SHALL be ignored.
REQ-020 RUN, load-use only: load_pc=load_if_id=0, load_id_ex=1 with flush_id_ex=1, load_ex_mem=load_mem_wb=1, next LU_STALL.
REQ-021 RUN, no event: all loads 1, flushes 0, next RUN.
REQ-022 LU_STALL SHALL last exactly one cycle, apply RUN decision rules except load-use detection (suppressed), then follow RUN next-state rules.
REQ-023 MEM_WAIT, mem_ready=0: all loads/flushes 0; wait_cnt increments; if wait_cnt==TIMEOUT next FAULT.
REQ-024 MEM_WAIT, mem_ready=1: cycle behaves as a RUN cycle with memory not blocking (jump/load-use applied), wait_cnt cleared, next state per RUN rules.
REQ-025 FAULT: all loads/flushes 0, mem_timeout=1, held until reset; inputs ignored.
REQ-026 Total blocked cycles for a never-ready access SHALL equal TIMEOUT before FAULT entry.

Reset
REQ-027 reset low SHALL immediately force state=RUN, wait_cnt=0, mem_timeout=0, all loads 0, all flushes 0, independent of clock.
REQ-028 Reset assertion mid-MEM_WAIT or in FAULT SHALL abandon the operation; first cycle after release is RUN.

Configuration
REQ-029 With PIPE_HAZARD_PERF_EN defined: outputs stall_cycles (16) counting cycles with load_pc=0 and reset high, flush_events (16) counting RUN-rule jump flushes; both saturate at 0xFFFF, clear on reset.
REQ-030 Without PIPE_HAZARD_PERF_EN: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-031 ex_mem_read=1, ex_dest=5, id_rs=5 -> one cycle load_pc=0, flush_id_ex=1, state=1; next cycle all loads 1, state=0.
REQ-032 ex_dest=0 with id_rs=0, ex_mem_read=1 -> no stall, all loads 1.
REQ-033 mem_jmp=1 with load-use present -> three flushes=1, all loads 1, state stays 0.
REQ-034 mem_access=1, mem_ready low 3 cycles then high -> 3 cycles all loads 0 (state=2), 4th cycle all loads 1, state returns 0.
REQ-035 TIMEOUT=4, mem_ready never high -> after 4 blocked cycles state=3, mem_timeout=1; reset low -> state=0 immediately.
REQ-036 PIPE_HAZARD_PERF_EN defined, one load-use stall plus 3-cycle memory wait -> stall_cycles=4, flush_events=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, jump flushes and data-memory waits with a timeout fault.
// Optional performance counters (stall_cycles, flush_events) are enabled by defining PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_dest,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       mem_jmp,
  input  logic       mem_access,
  input  logic       mem_ready,
  output logic       load_pc,
  output logic       load_if_id,
  output logic       load_id_ex,
  output logic       load_ex_mem,
  output logic       load_mem_wb,
  output logic       flush_if_id,
  output logic       flush_id_ex,
  output logic       flush_ex_mem,
  output logic [1:0] state,
  output logic       mem_timeout
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_events
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    FAULT    = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t     state_reg, state_next;
  logic [7:0] wait_cnt_reg, wait_cnt_next;
  logic       mem_timeout_reg;
  logic       lu_hazard;
  logic       jump_flush;

  assign lu_hazard = ex_mem_read && (ex_dest != 5'd0) &&
                     ((ex_dest == id_rs) || (id_uses_rt && (ex_dest == id_rt)));

  always_comb begin
    load_pc       = 1'b0;
    load_if_id    = 1'b0;
    load_id_ex    = 1'b0;
    load_ex_mem   = 1'b0;
    load_mem_wb   = 1'b0;
    flush_if_id   = 1'b0;
    flush_id_ex   = 1'b0;
    flush_ex_mem  = 1'b0;
    jump_flush    = 1'b0;
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;

    if (state_reg != FAULT) begin
      if (state_reg == MEM_WAIT && !mem_ready) begin
        // wait_cnt already counts the blocked cycle that entered MEM_WAIT
        wait_cnt_next = 8'(wait_cnt_reg + 8'd1);
        if (wait_cnt_next == TIMEOUT_CNT) state_next = FAULT;
      end else if (state_reg != MEM_WAIT && mem_access && !mem_ready) begin
        state_next    = MEM_WAIT;
        wait_cnt_next = 8'd1;
      end else begin
        wait_cnt_next = 8'd0;
        state_next    = RUN;
        if (mem_jmp) begin
          {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb} = 5'b11111;
          {flush_if_id, flush_id_ex, flush_ex_mem} = 3'b111;
          jump_flush = 1'b1;
        end else if (lu_hazard && state_reg != LU_STALL) begin
          {load_id_ex, load_ex_mem, load_mem_wb} = 3'b111;
          flush_id_ex = 1'b1;
          state_next  = LU_STALL;
        end else begin
          {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb} = 5'b11111;
        end
      end
    end

    if (!reset) begin
      {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb} = 5'b00000;
      {flush_if_id, flush_id_ex, flush_ex_mem} = 3'b000;
      jump_flush = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg       <= RUN;
      wait_cnt_reg    <= 8'd0;
      mem_timeout_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (state_next == FAULT) mem_timeout_reg <= 1'b1;
    end
  end

  assign state       = state_reg;
  assign mem_timeout = mem_timeout_reg;

`ifdef PIPE_HAZARD_PERF_EN
  logic [15:0] stall_cycles_reg, flush_events_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cycles_reg <= 16'd0;
      flush_events_reg <= 16'd0;
    end else begin
      if (!load_pc && stall_cycles_reg != 16'hFFFF)
        stall_cycles_reg <= stall_cycles_reg + 16'd1;
      if (jump_flush && flush_events_reg != 16'hFFFF)
        flush_events_reg <= flush_events_reg + 16'd1;
    end
  end

  assign stall_cycles = stall_cycles_reg;
  assign flush_events = flush_events_reg;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl (TIMEOUT=4); perf counters checked when PIPE_HAZARD_PERF_EN is defined.
module tb_pipe_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ex_mem_read = 1'b0;
  logic [4:0] ex_dest = 5'd0;
  logic [4:0] id_rs = 5'd0;
  logic [4:0] id_rt = 5'd0;
  logic       id_uses_rt = 1'b0;
  logic       mem_jmp = 1'b0;
  logic       mem_access = 1'b0;
  logic       mem_ready = 1'b0;
  logic       load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic       flush_if_id, flush_id_ex, flush_ex_mem;
  logic [1:0] state;
  logic       mem_timeout;
`ifdef PIPE_HAZARD_PERF_EN
  logic [15:0] stall_cycles, flush_events;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  pipe_hazard_ctrl #(.TIMEOUT(4)) dut (
    .clock(clock), .reset(reset),
    .ex_mem_read(ex_mem_read), .ex_dest(ex_dest), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .mem_jmp(mem_jmp), .mem_access(mem_access), .mem_ready(mem_ready),
    .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
    .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
    .state(state), .mem_timeout(mem_timeout)
`ifdef PIPE_HAZARD_PERF_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // loads packed as {pc,if_id,id_ex,ex_mem,mem_wb}, flushes as {if_id,id_ex,ex_mem}
  task automatic check_outs(input string tag, input logic [4:0] ld, input logic [2:0] fl,
                            input logic [1:0] st);
    check({tag, ".loads"}, {27'd0, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb}, {27'd0, ld});
    check({tag, ".flush"}, {29'd0, flush_if_id, flush_id_ex, flush_ex_mem}, {29'd0, fl});
    check({tag, ".state"}, {30'd0, state}, {30'd0, st});
  endtask

  task automatic drive(input logic emr, input logic [4:0] ed, input logic [4:0] rs,
                       input logic [4:0] rt, input logic urt, input logic jmp,
                       input logic acc, input logic rdy);
    ex_mem_read = emr; ex_dest = ed; id_rs = rs; id_rt = rt;
    id_uses_rt = urt; mem_jmp = jmp; mem_access = acc; mem_ready = rdy;
    #2;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #2;
    check_outs("reset", 5'b00000, 3'b000, 2'd0);
    check("reset.timeout", {31'd0, mem_timeout}, 32'd0);
    step();
    reset = 1'b1;

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check_outs("idle", 5'b11111, 3'b000, 2'd0);
    step();

    // load-use on rs: one stall cycle, then proceed with detection suppressed
    drive(1, 5, 5, 0, 0, 0, 0, 0);
    check_outs("lu_rs", 5'b00111, 3'b010, 2'd0);
    step();
    drive(1, 5, 5, 0, 0, 0, 0, 0);
    check_outs("lu_rs.stall", 5'b11111, 3'b000, 2'd1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check_outs("lu_rs.after", 5'b11111, 3'b000, 2'd0);
    step();

    drive(1, 7, 3, 7, 1, 0, 0, 0);
    check_outs("lu_rt", 5'b00111, 3'b010, 2'd0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check_outs("lu_rt.stall", 5'b11111, 3'b000, 2'd1);
    step();

    drive(1, 7, 3, 7, 0, 0, 0, 0);
    check_outs("rt_unused", 5'b11111, 3'b000, 2'd0);
    step();

    drive(1, 0, 0, 0, 0, 0, 0, 0);
    check_outs("dest_zero", 5'b11111, 3'b000, 2'd0);
    step();

    drive(1, 5, 5, 0, 0, 1, 0, 0);
    check_outs("jmp_lu", 5'b11111, 3'b111, 2'd0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check_outs("jmp_lu.after", 5'b11111, 3'b000, 2'd0);
    step();

    // memory not ready for three cycles, ready on the fourth
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    check_outs("mw.c1", 5'b00000, 3'b000, 2'd0);
    step();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    check_outs("mw.c2", 5'b00000, 3'b000, 2'd2);
    step();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    check_outs("mw.c3", 5'b00000, 3'b000, 2'd2);
    step();
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    check_outs("mw.ready", 5'b11111, 3'b000, 2'd2);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check_outs("mw.after", 5'b11111, 3'b000, 2'd0);
    step();

    // completion cycle carrying a jump flushes like a RUN cycle
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    check_outs("mwj.c1", 5'b00000, 3'b000, 2'd0);
    step();
    drive(0, 0, 0, 0, 0, 1, 1, 1);
    check_outs("mwj.ready", 5'b11111, 3'b111, 2'd2);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check_outs("mwj.after", 5'b11111, 3'b000, 2'd0);
`ifdef PIPE_HAZARD_PERF_EN
    // stalls: two load-use cycles, three + one blocked memory cycles; two jump flushes
    check("perf.stall", {16'd0, stall_cycles}, 32'd6);
    check("perf.flush", {16'd0, flush_events}, 32'd2);
`endif
    step();

    // never-ready access: four blocked cycles then FAULT
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      check_outs($sformatf("to.c%0d", i + 1), 5'b00000, 3'b000, (i == 0) ? 2'd0 : 2'd2);
      check($sformatf("to.c%0d.timeout", i + 1), {31'd0, mem_timeout}, 32'd0);
      step();
    end
    drive(1, 5, 5, 0, 0, 1, 1, 1);
    check_outs("fault", 5'b00000, 3'b000, 2'd3);
    check("fault.timeout", {31'd0, mem_timeout}, 32'd1);
    step();
    check_outs("fault.held", 5'b00000, 3'b000, 2'd3);

    reset = 1'b0;
    #1;
    check_outs("fault.rst", 5'b00000, 3'b000, 2'd0);
    check("fault.rst.timeout", {31'd0, mem_timeout}, 32'd0);
`ifdef PIPE_HAZARD_PERF_EN
    check("perf.rst", {16'd0, stall_cycles}, 32'd0);
`endif
    #1;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check_outs("post_rst", 5'b11111, 3'b000, 2'd0);
    step();
    check_outs("post_rst.run", 5'b11111, 3'b000, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog");
  end

endmodule
